// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch
//
// Fetch stage sitting directly in front of the instruction decoder. Holds the
// program counter, issues single-word reads to instruction memory over a
// req/ack handshake, and presents each fetched word (with the address it came
// from) to the decoder over a valid/ready handshake. Control-flow redirects
// are accepted in every state except S_HALT.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   defined   : a captured word equal to HALT_ENCODE stops fetching for good
//               (until reset) and raises the sticky halted flag.
//   undefined : HALT_ENCODE is an ordinary instruction, halted is always 0.
//
// Parameters:
//   RESET_PC     PC loaded on reset (word aligned)
//   HALT_ENCODE  instruction word that stops fetching
//
// Ports:
//   clk             in   sole clock, rising edge
//   rst             in   synchronous active-high reset
//   mem_req         out  read request to instruction memory
//   mem_addr        out  word-aligned read address, stable while mem_req=1
//   mem_ack         in   memory returns mem_rdata this cycle
//   mem_rdata       in   read data, taken when mem_req && mem_ack
//   instr_valid     out  instruction/pc_out valid for the decoder
//   instr_ready     in   decoder accepts
//   instruction     out  fetched word
//   pc_out          out  address the instruction was fetched from
//   redirect_valid  in   load a new PC
//   redirect_pc     in   redirect target, bits [1:0] ignored
//   halted          out  sticky, fetch stopped on HALT_ENCODE
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] HALT_ENCODE = 32'h0000_003F
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  // state  | meaning
  // S_REQ  | read outstanding at r_pc (idle while r_in_rst)
  // S_HOLD | word presented to the decoder, waiting for ready
  // S_KILL | read at r_pc still outstanding, its data will be dropped
  // S_HALT | halt word seen, everything idle until reset

`ifdef FETCH_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_KILL, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_halted;
  logic        r_in_rst;

  logic        w_req;
  logic        w_fire;
  logic        w_halt_hit;
  logic [31:0] w_redir;
  logic [31:0] w_pc_inc;
  logic        w_unused_redir_lsb;

  assign w_redir            = {redirect_pc[31:2], 2'b00};
  assign w_unused_redir_lsb = ^redirect_pc[1:0];
  assign w_pc_inc           = r_pc + 32'd4;

  // r_in_rst keeps mem_req low through the whole reset window without a
  // combinational path from rst to the output.
  assign w_req      = ((r_state == S_REQ) && !r_in_rst) || (r_state == S_KILL);
  assign w_fire     = w_req && mem_ack;
  assign w_halt_hit = HALT_EN && (mem_rdata == HALT_ENCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
      r_instr  <= 32'h0;
      r_pc_out <= RESET_PC;
      r_halted <= 1'b0;
      r_in_rst <= 1'b1;
    end else begin
      r_in_rst <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (redirect_valid) begin
            if (w_req && !mem_ack) begin
              // request cannot be withdrawn: remember target, drop the data
              r_target <= w_redir;
              r_state  <= S_KILL;
            end else begin
              r_pc <= w_redir;
            end
          end else if (w_fire) begin
            if (w_halt_hit) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_instr  <= mem_rdata;
              r_pc_out <= r_pc;
              r_pc     <= w_pc_inc;
              r_state  <= S_HOLD;
            end
          end
        end
        S_KILL: begin
          if (mem_ack) begin
            // a redirect arriving with the ack is the newest target
            r_pc    <= redirect_valid ? w_redir : r_target;
            r_state <= S_REQ;
          end else if (redirect_valid) begin
            r_target <= w_redir;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_redir;
            r_state <= S_REQ;
          end else if (instr_ready) begin
            r_state <= S_REQ;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  assign mem_req     = w_req;
  assign mem_addr    = r_pc;
  assign instr_valid = (r_state == S_HOLD);
  assign instruction = r_instr;
  assign pc_out      = r_pc_out;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'h0000_003F;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halted;

  int checks   = 0;
  int failures = 0;
  int wait_states = 0;
  int wcnt = 0;
  bit put_halt = 1'b0;

  instruction_fetch #(
    .RESET_PC    (RESET_PC),
    .HALT_ENCODE (HALT_WORD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0020;
    if (a == 32'h4) return 32'h0000_0022;
    if (a == 32'h8 && put_halt) return HALT_WORD;
    return {8'hA5, a[23:0]};
  endfunction

  // Instruction memory with a programmable number of wait states.
  always begin
    @(posedge clk);
    #2;
    if (rst || mem_req !== 1'b1) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      wcnt      = 0;
    end else begin
      mem_ack   = (wcnt >= wait_states);
      mem_rdata = mem_word(mem_addr);
      wcnt      = mem_ack ? 0 : wcnt + 1;
    end
  end

  // Transaction-level reference: expected request address, kill pending,
  // queue of words owed to the decoder, halt status.
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_target = RESET_PC;
  logic [31:0] m_redir;
  bit          m_kill = 1'b0;
  bit          m_halted = 1'b0;
  bit          prev_rst = 1'b0;

  always @(negedge clk) begin
    m_redir = redirect_pc & 32'hFFFF_FFFC;
    if (rst) begin
      if (prev_rst) begin
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_pc_out", pc_out, RESET_PC);
        chk("rst_mem_addr", mem_addr, RESET_PC);
      end
      q_pc.delete();
      q_ins.delete();
      m_pc     = RESET_PC;
      m_target = RESET_PC;
      m_kill   = 1'b0;
      m_halted = 1'b0;
    end else begin
      chk1("halted", halted, m_halted);
      if (m_halted) begin
        chk1("halt_mem_req", mem_req, 1'b0);
        chk1("halt_instr_valid", instr_valid, 1'b0);
      end else begin
        if (mem_req) chk("mem_addr", mem_addr, m_pc);
        if (instr_valid) begin
          chk1("req_during_valid", mem_req, 1'b0);
          if (q_pc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got pc_out %h expected no word at %0t", pc_out, $time);
          end else begin
            chk("instruction", instruction, q_ins[0]);
            chk("pc_out", pc_out, q_pc[0]);
          end
        end
        if (!prev_rst) chk1("fetch_activity", mem_req | instr_valid, 1'b1);

        if (instr_valid && (instr_ready || redirect_valid) && q_pc.size() > 0) begin
          void'(q_pc.pop_front());
          void'(q_ins.pop_front());
        end
        if (instr_valid && redirect_valid) m_pc = m_redir;
        if (mem_req && mem_ack) begin
          if (m_kill || redirect_valid) begin
            m_pc   = redirect_valid ? m_redir : m_target;
            m_kill = 1'b0;
          end else if (HALT_EN && mem_rdata == HALT_WORD) begin
            m_halted = 1'b1;
          end else begin
            q_pc.push_back(m_pc);
            q_ins.push_back(mem_rdata);
            m_pc = m_pc + 32'd4;
          end
        end else if (mem_req && redirect_valid) begin
          m_kill   = 1'b1;
          m_target = m_redir;
        end else if (!mem_req && !instr_valid && redirect_valid) begin
          m_pc = m_redir;
        end
      end
    end
    prev_rst = rst;
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    bit found;
    // reset values
    repeat (3) adv();
    mid();
    chk1("t0_mem_req", mem_req, 1'b0);
    chk1("t0_instr_valid", instr_valid, 1'b0);
    chk1("t0_halted", halted, 1'b0);
    chk("t0_instruction", instruction, 32'h0);
    chk("t0_pc_out", pc_out, 32'h0);
    chk("t0_mem_addr", mem_addr, 32'h0);

    // zero-wait streaming
    adv(); rst = 1'b0; instr_ready = 1'b1; mid();
    chk1("t1_idle_after_release", mem_req, 1'b0);
    adv(); mid();
    chk1("t1_req0", mem_req, 1'b1);
    chk("t1_addr0", mem_addr, 32'h0);
    adv(); mid();
    chk1("t1_valid0", instr_valid, 1'b1);
    chk("t1_instr0", instruction, 32'h0000_0020);
    chk("t1_pc0", pc_out, 32'h0);
    adv(); mid();
    chk1("t1_valid_gap", instr_valid, 1'b0);
    chk("t1_addr1", mem_addr, 32'h4);
    adv(); mid();
    chk1("t1_valid1", instr_valid, 1'b1);
    chk("t1_instr1", instruction, 32'h0000_0022);
    chk("t1_pc1", pc_out, 32'h4);

    // decoder back-pressure
    adv(); instr_ready = 1'b0; mid();
    chk("t2_addr8", mem_addr, 32'h8);
    for (int i = 0; i < 5; i++) begin
      adv(); mid();
      chk1("t2_hold_valid", instr_valid, 1'b1);
      chk1("t2_hold_noreq", mem_req, 1'b0);
      chk("t2_hold_instr", instruction, 32'hA500_0008);
      chk("t2_hold_pc", pc_out, 32'h8);
    end
    adv(); instr_ready = 1'b1; mid();
    chk1("t2_transfer", instr_valid, 1'b1);
    adv(); mid();
    chk1("t2_next_req", mem_req, 1'b1);
    chk("t2_next_addr", mem_addr, 32'hC);

    // redirect during a 3-wait-state read
    adv(); wait_states = 3; mid();
    chk("t3_pc_c", pc_out, 32'hC);
    adv(); mid();
    chk("t3_addr_w0", mem_addr, 32'h10);
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; mid();
    chk("t3_addr_w1", mem_addr, 32'h10);
    adv(); redirect_valid = 1'b0; mid();
    chk1("t3_req_w2", mem_req, 1'b1);
    chk("t3_addr_w2", mem_addr, 32'h10);
    adv(); mid();
    chk("t3_addr_ack", mem_addr, 32'h10);
    chk1("t3_novalid_ack", instr_valid, 1'b0);

    // two more redirects while the killed read is outstanding
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h200; mid();
    chk1("t3_killed_novalid", instr_valid, 1'b0);
    chk("t3_new_addr", mem_addr, 32'h100);
    adv(); redirect_pc = 32'h40; mid();
    adv(); redirect_pc = 32'h80; mid();
    adv(); redirect_valid = 1'b0; mid();
    chk1("t4_novalid", instr_valid, 1'b0);
    adv(); mid();
    chk("t4_newest_target", mem_addr, 32'h80);
    repeat (3) begin adv(); mid(); end
    adv(); wait_states = 0; mid();
    chk("t4_pc80", pc_out, 32'h80);
    chk("t4_instr80", instruction, 32'hA500_0080);
    adv(); mid();
    chk("t4_addr84", mem_addr, 32'h84);

    // redirect in S_HOLD to top of memory, then wrap
    adv(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; mid();
    chk("t5_pc84", pc_out, 32'h84);
    adv(); redirect_valid = 1'b0; mid();
    chk("t5_addr_top", mem_addr, 32'hFFFF_FFFC);
    adv(); put_halt = 1'b1; mid();
    chk("t5_pc_top", pc_out, 32'hFFFF_FFFC);
    chk("t5_instr_top", instruction, 32'hA5FF_FFFC);
    adv(); mid();
    chk("t5_wrap_addr", mem_addr, 32'h0);

    // halt word at 0x8
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h8; mid();
    chk("t6_pc0", pc_out, 32'h0);
    adv(); redirect_valid = 1'b0; mid();
    chk("t6_addr8", mem_addr, 32'h8);
    adv(); mid();
`ifdef FETCH_HALT_DETECT_EN
    chk1("t6_halted", halted, 1'b1);
    chk1("t6_no_valid", instr_valid, 1'b0);
    chk1("t6_no_req", mem_req, 1'b0);
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h40; mid();
    adv(); redirect_valid = 1'b0; mid();
    for (int i = 0; i < 4; i++) begin
      adv(); mid();
      chk1("t6_stay_halted", halted, 1'b1);
      chk1("t6_stay_noreq", mem_req, 1'b0);
      chk1("t6_stay_novalid", instr_valid, 1'b0);
    end
`else
    chk1("t6_valid", instr_valid, 1'b1);
    chk("t6_instr", instruction, HALT_WORD);
    chk("t6_pc8", pc_out, 32'h8);
    chk1("t6_not_halted", halted, 1'b0);
`endif

    // reset in the middle of a killed read
    adv(); rst = 1'b1; put_halt = 1'b0; wait_states = 3; mid();
    adv(); mid();
    chk1("t7_rst_halted", halted, 1'b0);
    adv(); rst = 1'b0; mid();
    chk1("t7_idle", mem_req, 1'b0);
    adv(); mid();
    chk("t7_addr0", mem_addr, 32'h0);
    adv(); redirect_valid = 1'b1; redirect_pc = 32'h300; mid();
    adv(); redirect_valid = 1'b0; rst = 1'b1; mid();
    adv(); mid();
    chk1("t7_rst_noreq", mem_req, 1'b0);
    adv(); rst = 1'b0; wait_states = 0; mid();
    chk1("t7_release_noreq", mem_req, 1'b0);
    adv(); mid();
    chk1("t7_req", mem_req, 1'b1);
    chk("t7_req_addr", mem_addr, RESET_PC);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      adv(); mid();
      found = instr_valid;
    end
    chk1("t7_valid_seen", found, 1'b1);
    chk("t7_pc_out", pc_out, RESET_PC);
    chk("t7_instr", instruction, 32'h0000_0020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage directly upstream of the instruction decoder.
- Holds the program counter and issues single-word read requests to instruction memory over a req/ack handshake.
- Presents each fetched word to the decoder over a valid/ready handshake.
- Handles control-flow redirects and optionally halt detection.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- HALT_ENCODE, 32'h0000_003F, instruction word that stops fetching (opcode 0, funct 6'b111111)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_req  output  1  read request to instruction memory
- mem_addr  output  32  word-aligned read address; stable while mem_req=1
- mem_ack  input  1  memory has returned mem_rdata this cycle; valid only while mem_req=1
- mem_rdata  input  32  read data, sampled when mem_req&&mem_ack
- instr_valid  output  1  instruction/pc_out valid for decoder
- instr_ready  input  1  decoder accepts; transfer when instr_valid&&instr_ready
- instruction  output  32  fetched word
- pc_out  output  32  address the instruction was fetched from
- redirect_valid  input  1  load new PC (branch/jump)
- redirect_pc  input  32  target; bits [1:0] ignored, forced to 00
- halted  output  1  sticky; fetch stopped on HALT_ENCODE

## Operation
- States:
  - S_REQ: mem_req=1, mem_addr=pc.
  - S_HOLD: instr_valid=1.
  - S_KILL: mem_req=1, old address, result to be discarded.
  - S_HALT: all handshakes idle.
- Reset: state=S_REQ, pc=RESET_PC.
  - While rst=1: mem_req=0, instr_valid=0, halted=0, instruction=0, pc_out=RESET_PC, mem_addr=RESET_PC.
- S_REQ, no redirect:
  - mem_ack: instruction<=mem_rdata, pc_out<=pc, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0), go S_HOLD.
  - No ack: stay; mem_addr held.
- S_REQ + redirect_valid:
  - Same-cycle mem_ack: discard data, pc<=redirect_pc, stay S_REQ.
  - No ack: latch target, go S_KILL; the outstanding request is never withdrawn.
- S_KILL:
  - mem_req held at old address.
  - Further redirects overwrite the latched target (newest wins).
  - On mem_ack: data discarded, pc<=latched target, go S_REQ.
- S_HOLD:
  - On transfer: go S_REQ.
  - redirect_valid: pc<=redirect_pc, instr_valid drops next cycle, go S_REQ. A transfer in the same cycle still counts as delivered.
  - Neither: hold instruction/pc_out stable.
- S_HALT: only rst leaves it; redirect_valid is ignored.

## Timing
- mem_ack may arrive in the first cycle mem_req is high (zero wait states).
- Ack in cycle N -> instr_valid high in N+1.
- Best case 2 cycles per instruction: S_REQ/ack, then S_HOLD/ready.
- Redirect to first new mem_addr on mem_req:
  - 1 cycle from S_REQ-with-ack or S_HOLD.
  - 1 cycle after the outstanding ack from S_KILL.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - A word equal to HALT_ENCODE captured in S_REQ (not discarded) sets halted=1 the next cycle.
  - State goes to S_HALT; the word is not presented (instr_valid stays 0) and pc is not incremented.
- Undefined:
  - HALT_ENCODE is forwarded as an ordinary instruction.
  - halted is tied 0 and S_HALT is unreachable.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning 0x0000_0020, 0x0000_0022; instr_ready=1 -> mem_addr 0x0, 0x4; instr_valid every other cycle; pc_out 0x0 then 0x4.
- instr_ready=0 for 5 cycles after a fetch -> instruction/pc_out constant, mem_req=0; ready asserted -> next mem_addr = previous+4.
- 3-wait-state memory, redirect_valid to 0x0000_0103 in 2nd wait cycle -> mem_addr stays old until ack, data discarded, then mem_addr=0x0000_0100, instr_valid never set for the killed word.
- Two redirects (0x40 then 0x80) during S_KILL -> next request address 0x80.
- With FETCH_HALT_DETECT_EN, mem_rdata=0x0000_003F at 0x8 -> halted=1, instr_valid=0, mem_req=0 indefinitely, redirect ignored; without it -> word presented with pc_out=0x8.
- pc=0xFFFF_FFFC fetched -> next mem_addr 0x0; rst asserted mid-S_KILL -> mem_req=0 during rst, first request after release at RESET_PC.
